// File: rtl/dmem_responder.sv
// Word-organised data memory with byte-enable stores and fixed-latency loads.
// Optional build macro DMEM_MISALIGN_CHK_EN enables address/byte-enable alignment checking.
module dmem_responder #(
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        state_dbg
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              err_q, err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [31:0]       mem [DEPTH];
    logic              accept;
    logic              mem_we;
    logic              req_oor;
    logic              req_misalign;
    logic [AW-1:0]     req_idx;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // the requester must hold an unaccepted request stable until then.
    assign accept  = req_valid && (state_q == ST_IDLE);
    assign req_idx = req_addr[AW+1:2];
    assign req_oor = (req_addr[31:2] >= 30'(DEPTH));

`ifdef DMEM_MISALIGN_CHK_EN
    always_comb begin
        req_misalign = 1'b1;
        case (req_be)
            4'b0000: req_misalign = !req_we;
            4'b0001: req_misalign = (req_addr[1:0] != 2'd0);
            4'b0010: req_misalign = (req_addr[1:0] != 2'd1);
            4'b0100: req_misalign = (req_addr[1:0] != 2'd2);
            4'b1000: req_misalign = (req_addr[1:0] != 2'd3);
            4'b0011: req_misalign = (req_addr[1:0] != 2'd0);
            4'b1100: req_misalign = (req_addr[1:0] != 2'd2);
            4'b1111: req_misalign = (req_addr[1:0] != 2'd0);
            default: req_misalign = 1'b1;
        endcase
    end
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];
    assign req_misalign    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && !req_we) state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == 3'd0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM is read at the response edge, so a store just before a load is visible.
    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_we) begin
                        if (req_misalign) begin
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                            rsp_rdata_d = 32'd0;
                        end else begin
                            mem_we = !req_oor;
                        end
                    end else begin
                        cnt_d = 3'(READ_LAT - 1);
                        idx_d = req_idx;
                        err_d = req_oor || req_misalign;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = err_q ? 32'd0 : mem[idx_q];
                    rsp_err_d   = err_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = !req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (READ_LAT 1, 2, 7) checked against a word-array model.
module tb_dmem_responder;

    localparam int NI    = 3;
    localparam int DEPTH = 1024;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NI-1:0]        req_valid;
    logic [NI-1:0]        req_we;
    logic [NI-1:0][31:0]  req_addr;
    logic [NI-1:0][31:0]  req_wdata;
    logic [NI-1:0][3:0]   req_be;
    logic [NI-1:0]        req_ready;
    logic [NI-1:0]        busy;
    logic [NI-1:0]        rsp_valid;
    logic [NI-1:0][31:0]  rsp_rdata;
    logic [NI-1:0]        rsp_err;
    logic [NI-1:0]        state_dbg;

    logic [31:0] mm [NI][DEPTH];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH(DEPTH),
            .READ_LAT(g == 0 ? 1 : (g == 1 ? 2 : 7))
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .req_valid(req_valid[g]),
            .req_we(req_we[g]),
            .req_addr(req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_be(req_be[g]),
            .req_ready(req_ready[g]),
            .busy(busy[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err(rsp_err[g]),
            .state_dbg(state_dbg[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 7);
    endfunction

    // Access legal when the enabled bytes form one naturally aligned 1/2/4-byte unit.
    function automatic bit legal(input logic [1:0] a, input logic [3:0] be, input bit we);
`ifdef DMEM_MISALIGN_CHK_EN
        int n;
        n = $countones(be);
        if (we && be == 4'd0) return 1'b1;
        if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
        if ((int'(a) % n) != 0) return 1'b0;
        return be == 4'(((1 << n) - 1) << a);
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_store(input int k, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] be);
        bit mis, oor;
        mis = !legal(addr[1:0], be, 1'b1);
        oor = (addr[31:2] >= 30'(DEPTH));
        @(negedge clk);
        chk("st_ready", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_we[k]    = 1'b1;
        req_addr[k]  = addr;
        req_wdata[k] = data;
        req_be[k]    = be;
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
        if (!mis && !oor) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mm[k][addr[11:2]][8*i +: 8] = data[8*i +: 8];
        end
        chk("st_rsp_valid", 32'(rsp_valid[k]), 32'(mis));
        chk("st_ready_after", 32'(req_ready[k]), 32'd1);
        if (mis) begin
            chk("st_mis_err", 32'(rsp_err[k]), 32'd1);
            chk("st_mis_rdata", rsp_rdata[k], 32'd0);
        end
    endtask

    task automatic do_load(input int k, input logic [31:0] addr, input logic [3:0] be,
                           input bit hold_next, input logic [31:0] next_addr,
                           output logic [31:0] got);
        bit mis, oor;
        logic [31:0] exp;
        mis = !legal(addr[1:0], be, 1'b0);
        oor = (addr[31:2] >= 30'(DEPTH));
        @(negedge clk);
        chk("ld_ready", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_we[k]    = 1'b0;
        req_addr[k]  = addr;
        req_wdata[k] = $urandom;
        req_be[k]    = be;
        @(posedge clk);
        #1;
        if (hold_next) req_addr[k] = next_addr;
        else req_valid[k] = 1'b0;
        for (int i = 0; i < lat_of(k); i++) begin
            chk("ld_busy", {30'd0, busy[k], req_ready[k]}, 32'd2);
            chk("ld_no_early_rsp", 32'(rsp_valid[k]), 32'd0);
            @(posedge clk);
            #1;
        end
        exp = (mis || oor) ? 32'd0 : mm[k][addr[11:2]];
        chk("ld_rsp_valid", 32'(rsp_valid[k]), 32'd1);
        chk("ld_busy_done", 32'(busy[k]), 32'd0);
        chk("ld_rdata", rsp_rdata[k], exp);
        chk("ld_err", 32'(rsp_err[k]), 32'(mis || oor));
        got = rsp_rdata[k];
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [3:0]  be;
        reset     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_ready", 32'(req_ready[k]), 32'd1);
            chk("rst_busy", 32'(busy[k]), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            chk("rst_rdata", rsp_rdata[k], 32'd0);
            chk("rst_err", 32'(rsp_err[k]), 32'd0);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) chk("idle_rsp_valid", 32'(rsp_valid[k]), 32'd0);

        // Directed: word store/load, byte lane, back-to-back, range, alignment (READ_LAT=2)
        do_store(1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_load(1, 32'h10, 4'hF, 1'b0, 32'h0, got);
        chk("tp_deadbeef", got, 32'hDEADBEEF);
        do_store(1, 32'h10, 32'h000000AA, 4'h1);
        do_load(1, 32'h10, 4'hF, 1'b0, 32'h0, got);
        chk("tp_byte_lane", got, 32'hDEADBEAA);
        do_store(1, 32'h0, 32'h01020304, 4'hF);
        do_store(1, 32'h4, 32'h05060708, 4'hF);
        do_store(1, 32'h8, 32'h090A0B0C, 4'hF);
        do_load(1, 32'h0, 4'hF, 1'b0, 32'h0, got);
        chk("tp_b2b_0", got, 32'h01020304);
        do_load(1, 32'h4, 4'hF, 1'b0, 32'h0, got);
        chk("tp_b2b_4", got, 32'h05060708);
        do_load(1, 32'h8, 4'hF, 1'b0, 32'h0, got);
        chk("tp_b2b_8", got, 32'h090A0B0C);
        do_load(1, 32'h1000, 4'hF, 1'b0, 32'h0, got);
        chk("tp_oor_load", got, 32'd0);
        do_store(1, 32'h1000, 32'hFFFFFFFF, 4'hF);
        do_load(1, 32'h0, 4'hF, 1'b0, 32'h0, got);
        chk("tp_oor_store", got, 32'h01020304);
        do_store(1, 32'h12, 32'h12345678, 4'hF);
        do_load(1, 32'h10, 4'hF, 1'b0, 32'h0, got);
`ifdef DMEM_MISALIGN_CHK_EN
        chk("tp_misalign_dropped", got, 32'hDEADBEAA);
`else
        chk("tp_misalign_written", got, 32'h12345678);
`endif

        // Latency extremes, with a second load held while busy
        for (int k = 0; k < NI; k += 2) begin
            do_store(k, 32'h20, 32'hCAFE0000 + k, 4'hF);
            do_store(k, 32'h24, 32'hBEEF0000 + k, 4'hF);
            do_load(k, 32'h20, 4'hF, 1'b1, 32'h24, got);
            chk("lat_first", got, 32'hCAFE0000 + k);
            do_load(k, 32'h24, 4'hF, 1'b0, 32'h0, got);
            chk("lat_held", got, 32'hBEEF0000 + k);
        end

        // Randomized mix against the model
        for (int k = 0; k < NI; k++) begin
            for (int w = 0; w < 16; w++) do_store(k, 32'(w * 4), $urandom, 4'hF);
            for (int n = 0; n < 25; n++) begin
                if ($urandom_range(0, 1) == 0) begin
                    a  = 32'($urandom_range(0, 15) * 4);
                    be = 4'hF;
                end else begin
                    a  = 32'($urandom_range(0, 63));
                    be = 4'($urandom_range(0, 15));
                end
                if ($urandom_range(0, 9) == 0) a = a + 32'h1000;
                if ($urandom_range(0, 1) == 0) do_store(k, a, $urandom, be);
                else do_load(k, a, be, 1'b0, 32'h0, got);
            end
        end

        // Reset in the middle of a READ_LAT=7 load
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b0;
        req_addr[2]  = 32'h0;
        req_be[2]    = 4'hF;
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready[2]), 32'd1);
        chk("midrst_busy", 32'(busy[2]), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid[2]), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1 chk("midrst_no_rsp", 32'(rsp_valid[2]), 32'd0);
        end
        do_load(2, 32'h4, 4'hF, 1'b0, 32'h0, got);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
